// File: rtl/exu_csr_seq_pkg.sv
// exu_csr_seq_pkg
//   Shared definitions for the execute-stage CSR-port sequencer:
//   XLEN, machine-mode CSR addresses, mstatus bit positions, sequencer
//   state encoding and the mstatus rewrite helpers used on trap entry / mret.
//   Optional build macro: EXU_CSR_SEQ_MTVAL_EN (adds the T_TVAL state).
package exu_csr_seq_pkg;

   // xlen_def: datapath width is fixed for this core
   localparam int XLEN = 32;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      T_EPC    = 3'd1,
      T_CAUSE  = 3'd2,
`ifdef EXU_CSR_SEQ_MTVAL_EN
      T_TVAL   = 3'd7,
`endif
      T_STATUS = 3'd3,
      T_VEC    = 3'd4,
      R_STATUS = 3'd5,
      R_EPC    = 3'd6
   } seq_state_e;

   // Trap entry: stash MIE in MPIE, disable interrupts, previous mode = M.
   function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] s);
      logic [XLEN-1:0] r;
      r = s;
      r[MSTATUS_MPIE] = s[MSTATUS_MIE];
      r[MSTATUS_MIE]  = 1'b0;
      r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      return r;
   endfunction

   // mret: restore MIE from MPIE, set MPIE, MPP stays M (M-only core).
   function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] s);
      logic [XLEN-1:0] r;
      r = s;
      r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
      r[MSTATUS_MPIE] = 1'b1;
      r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      return r;
   endfunction

endpackage

// File: rtl/exu_csr_seq.sv
// exu_csr_seq
//   Owns the single read/write port of the CSR file and shares it between
//   the SCU instruction path (zero-latency, granted only in IDLE) and the
//   trap path (uninterruptible multi-cycle trap-entry / mret sequences).
//   Arbitration in IDLE: trap > mret > inst.
//   Build macro: EXU_CSR_SEQ_MTVAL_EN adds i_trap_tval and an mtval write.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_inst_*  / o_inst_*  SCU request (addr/wen/wdata), grant, read data
//   i_trap_*  / i_mret_req  level requests held until o_trap_ack
//   o_trap_ack, o_trap_vec  completion pulse and redirect PC
//   o_busy                sequence in progress
//   o_csr_* / i_csr_rdata CSR file port (combinational read)
module exu_csr_seq
   import exu_csr_seq_pkg::*;
(
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_inst_req,
   input  logic [11:0]     i_inst_addr,
   input  logic            i_inst_wen,
   input  logic [XLEN-1:0] i_inst_wdata,
   output logic            o_inst_gnt,
   output logic [XLEN-1:0] o_inst_rdata,
   input  logic            i_trap_req,
   input  logic [XLEN-1:0] i_trap_cause,
   input  logic [XLEN-1:0] i_trap_pc,
`ifdef EXU_CSR_SEQ_MTVAL_EN
   input  logic [XLEN-1:0] i_trap_tval,
`endif
   input  logic            i_mret_req,
   output logic            o_trap_ack,
   output logic [XLEN-1:0] o_trap_vec,
   output logic            o_busy,
   output logic [11:0]     o_csr_addr,
   output logic            o_csr_wen,
   output logic [XLEN-1:0] o_csr_wdata,
   input  logic [XLEN-1:0] i_csr_rdata
);

   seq_state_e      state;
   logic [XLEN-1:0] cause_q;
   logic [XLEN-1:0] pc_q;
`ifdef EXU_CSR_SEQ_MTVAL_EN
   logic [XLEN-1:0] tval_q;
`endif

   logic            accept_ok;
   logic            take_trap;
   logic            take_mret;
   logic            take_inst;

   // The requests are levels held until ack; in the ack cycle they are
   // still asserted but already serviced, so nothing is accepted then.
   assign accept_ok = (state == IDLE) && !o_trap_ack && !i_rst;
   assign take_trap = accept_ok && i_trap_req;
   assign take_mret = accept_ok && !i_trap_req && i_mret_req;
   assign take_inst = accept_ok && !i_trap_req && !i_mret_req && i_inst_req;

   assign o_inst_gnt   = take_inst;
   assign o_inst_rdata = i_csr_rdata;
   assign o_busy       = (state != IDLE);

   // CSR port mux. Held quiet while reset is asserted so a sequence cut
   // by reset does not issue its in-flight write.
   always_comb begin
      o_csr_addr  = '0;
      o_csr_wen   = 1'b0;
      o_csr_wdata = '0;
      if (!i_rst) begin
         case (state)
            IDLE: begin
               if (take_inst) begin
                  o_csr_addr  = i_inst_addr;
                  o_csr_wen   = i_inst_wen;
                  o_csr_wdata = i_inst_wdata;
               end
            end
            T_EPC: begin
               o_csr_addr  = CSR_MEPC;
               o_csr_wen   = 1'b1;
               o_csr_wdata = pc_q;
            end
            T_CAUSE: begin
               o_csr_addr  = CSR_MCAUSE;
               o_csr_wen   = 1'b1;
               o_csr_wdata = cause_q;
            end
`ifdef EXU_CSR_SEQ_MTVAL_EN
            T_TVAL: begin
               o_csr_addr  = CSR_MTVAL;
               o_csr_wen   = 1'b1;
               o_csr_wdata = tval_q;
            end
`endif
            T_STATUS: begin
               o_csr_addr  = CSR_MSTATUS;
               o_csr_wen   = 1'b1;
               o_csr_wdata = mstatus_on_trap(i_csr_rdata);
            end
            T_VEC: begin
               o_csr_addr = CSR_MTVEC;
            end
            R_STATUS: begin
               o_csr_addr  = CSR_MSTATUS;
               o_csr_wen   = 1'b1;
               o_csr_wdata = mstatus_on_mret(i_csr_rdata);
            end
            R_EPC: begin
               o_csr_addr = CSR_MEPC;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= IDLE;
         o_trap_ack <= 1'b0;
         o_trap_vec <= '0;
         cause_q    <= '0;
         pc_q       <= '0;
`ifdef EXU_CSR_SEQ_MTVAL_EN
         tval_q     <= '0;
`endif
      end else begin
         o_trap_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (take_trap) begin
                  cause_q <= i_trap_cause;
                  pc_q    <= i_trap_pc;
`ifdef EXU_CSR_SEQ_MTVAL_EN
                  tval_q  <= i_trap_tval;
`endif
                  state   <= T_EPC;
               end else if (take_mret) begin
                  state <= R_STATUS;
               end
            end
            T_EPC:   state <= T_CAUSE;
`ifdef EXU_CSR_SEQ_MTVAL_EN
            T_CAUSE: state <= T_TVAL;
            T_TVAL:  state <= T_STATUS;
`else
            T_CAUSE: state <= T_STATUS;
`endif
            T_STATUS: state <= T_VEC;
            T_VEC: begin
               // mtvec mode bits dropped: direct mode only
               o_trap_vec <= {i_csr_rdata[XLEN-1:2], 2'b00};
               o_trap_ack <= 1'b1;
               state      <= IDLE;
            end
            R_STATUS: state <= R_EPC;
            R_EPC: begin
               o_trap_vec <= {i_csr_rdata[XLEN-1:1], 1'b0};
               o_trap_ack <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exu_csr_seq.sv
// tb_exu_csr_seq
//   Directed bench for exu_csr_seq. A small CSR-file model answers reads;
//   stimulus pushes cycle-stamped expected port events (inst grant, CSR
//   write, trap ack) into a queue and a negedge monitor pops and compares.
//   Works in both builds (EXU_CSR_SEQ_MTVAL_EN defined or not).
module tb_exu_csr_seq;
   import exu_csr_seq_pkg::*;

`ifdef EXU_CSR_SEQ_MTVAL_EN
   localparam int TV = 1;
`else
   localparam int TV = 0;
`endif

   localparam int K_GNT = 0;
   localparam int K_WR  = 1;
   localparam int K_ACK = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req, inst_wen, trap_req, mret_req;
   logic [11:0] inst_addr;
   logic [31:0] inst_wdata, trap_cause, trap_pc, trap_tval;
   logic        inst_gnt, trap_ack, busy, csr_wen;
   logic [31:0] inst_rdata, trap_vec, csr_wdata, csr_rdata;
   logic [11:0] csr_addr;

   exu_csr_seq dut (
      .i_clk(clk), .i_rst(rst),
      .i_inst_req(inst_req), .i_inst_addr(inst_addr), .i_inst_wen(inst_wen),
      .i_inst_wdata(inst_wdata), .o_inst_gnt(inst_gnt), .o_inst_rdata(inst_rdata),
      .i_trap_req(trap_req), .i_trap_cause(trap_cause), .i_trap_pc(trap_pc),
`ifdef EXU_CSR_SEQ_MTVAL_EN
      .i_trap_tval(trap_tval),
`endif
      .i_mret_req(mret_req), .o_trap_ack(trap_ack), .o_trap_vec(trap_vec),
      .o_busy(busy), .o_csr_addr(csr_addr), .o_csr_wen(csr_wen),
      .o_csr_wdata(csr_wdata), .i_csr_rdata(csr_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // CSR file model, preloaded through the poke port
   logic [31:0] csr_mem [0:4095];
   logic        poke_en = 1'b0;
   logic [11:0] poke_addr = '0;
   logic [31:0] poke_data = '0;
   assign csr_rdata = csr_mem[csr_addr];
   always @(posedge clk) begin
      if (csr_wen) csr_mem[csr_addr] <= csr_wdata;
      if (poke_en) csr_mem[poke_addr] <= poke_data;
   end

   typedef struct {
      int          cyc;
      int          kind;
      logic [11:0] addr;
      logic        wen;
      logic [31:0] wdata;
      logic [31:0] data;
   } ev_t;
   ev_t exp_q[$];

   int errors = 0;
   int checks = 0;

   task automatic push(input int c, input int k, input logic [11:0] a,
                       input logic w, input logic [31:0] wd, input logic [31:0] d);
      ev_t e;
      e.cyc = c; e.kind = k; e.addr = a; e.wen = w; e.wdata = wd; e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cyc %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic chk_ev(input ev_t o);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: kind=%0d cyc=%0d addr=0x%0h wdata=0x%0h data=0x%0h",
                  o.kind, o.cyc, o.addr, o.wdata, o.data);
      end else begin
         e = exp_q.pop_front();
         if (e.cyc != o.cyc || e.kind != o.kind || e.addr !== o.addr ||
             e.wen !== o.wen || e.wdata !== o.wdata || e.data !== o.data) begin
            errors++;
            $display("FAIL event: got kind=%0d cyc=%0d addr=0x%0h wen=%0b wdata=0x%0h data=0x%0h; want kind=%0d cyc=%0d addr=0x%0h wen=%0b wdata=0x%0h data=0x%0h",
                     o.kind, o.cyc, o.addr, o.wen, o.wdata, o.data,
                     e.kind, e.cyc, e.addr, e.wen, e.wdata, e.data);
         end
      end
   endtask

   // Monitor: every visible port event is checked against the queue
   always @(negedge clk) begin
      ev_t o;
      if (trap_ack) begin
         o.cyc = cyc; o.kind = K_ACK; o.addr = '0; o.wen = 1'b0;
         o.wdata = '0; o.data = trap_vec;
         chk_ev(o);
      end
      if (inst_gnt) begin
         o.cyc = cyc; o.kind = K_GNT; o.addr = csr_addr; o.wen = csr_wen;
         o.wdata = csr_wdata; o.data = inst_rdata;
         chk_ev(o);
      end else if (csr_wen) begin
         o.cyc = cyc; o.kind = K_WR; o.addr = csr_addr; o.wen = 1'b1;
         o.wdata = csr_wdata; o.data = '0;
         chk_ev(o);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic [11:0] a, input logic [31:0] d);
      poke_en = 1'b1; poke_addr = a; poke_data = d;
      step();
      poke_en = 1'b0;
   endtask

   task automatic wait_ack(input string nm);
      checks++;
      for (int i = 0; i < 20; i++) begin
         step();
         if (trap_ack) return;
      end
      errors++;
      $display("FAIL %s: no ack within 20 cycles", nm);
   endtask

   int n, a;

   initial begin
      rst = 1'b1;
      inst_req = 0; inst_wen = 0; inst_addr = '0; inst_wdata = '0;
      trap_req = 0; trap_cause = '0; trap_pc = '0; trap_tval = '0; mret_req = 0;
      step(); step();
      chk("rst_ack", 32'(trap_ack), 0);
      chk("rst_vec", trap_vec, 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_gnt", 32'(inst_gnt), 0);
      chk("rst_wen", 32'(csr_wen), 0);
      chk("rst_addr", 32'(csr_addr), 0);
      chk("rst_wdata", csr_wdata, 0);
      rst = 1'b0;
      poke(CSR_MSTATUS, 32'h8);
      poke(CSR_MTVEC, 32'h2001);
      poke(12'h340, 32'h0);
      chk("idle_addr", 32'(csr_addr), 0);
      chk("idle_wen", 32'(csr_wen), 0);

      // inst write then inst read, zero latency
      inst_req = 1; inst_addr = 12'h300; inst_wen = 1; inst_wdata = 32'h8;
      push(cyc, K_GNT, 12'h300, 1'b1, 32'h8, 32'h8);
      chk("inst_busy", 32'(busy), 0);
      step();
      inst_addr = 12'h305; inst_wen = 0; inst_wdata = 32'h55;
      push(cyc, K_GNT, 12'h305, 1'b0, 32'h55, 32'h2001);
      step();
      inst_req = 0;
      step();

      // trap entry
      trap_req = 1; trap_cause = 32'hB; trap_pc = 32'h1000; trap_tval = 32'hDEAD;
      n = cyc;
      push(n + 1, K_WR, CSR_MEPC, 1'b1, 32'h1000, 0);
      push(n + 2, K_WR, CSR_MCAUSE, 1'b1, 32'hB, 0);
      if (TV == 1) push(n + 3, K_WR, CSR_MTVAL, 1'b1, 32'hDEAD, 0);
      push(n + 3 + TV, K_WR, CSR_MSTATUS, 1'b1, 32'h1880, 0);
      push(n + 5 + TV, K_ACK, '0, 1'b0, 0, 32'h2000);
      step();
      chk("trap_busy", 32'(busy), 1);
      wait_ack("trap");
      chk("trap_ack_busy", 32'(busy), 0);
      trap_req = 0;
      step();

      // mret
      poke(CSR_MEPC, 32'h1003);
      mret_req = 1;
      n = cyc;
      push(n + 1, K_WR, CSR_MSTATUS, 1'b1, 32'h1888, 0);
      push(n + 3, K_ACK, '0, 1'b0, 0, 32'h1002);
      wait_ack("mret");
      mret_req = 0;
      step();

      // trap + mret + inst together
      poke(CSR_MSTATUS, 32'h8);
      trap_req = 1; trap_cause = 32'h7; trap_pc = 32'h2004; trap_tval = 32'hBEEF;
      mret_req = 1;
      inst_req = 1; inst_addr = 12'h340; inst_wen = 1; inst_wdata = 32'h77;
      n = cyc;
      a = n + 5 + TV;
      push(n + 1, K_WR, CSR_MEPC, 1'b1, 32'h2004, 0);
      push(n + 2, K_WR, CSR_MCAUSE, 1'b1, 32'h7, 0);
      if (TV == 1) push(n + 3, K_WR, CSR_MTVAL, 1'b1, 32'hBEEF, 0);
      push(n + 3 + TV, K_WR, CSR_MSTATUS, 1'b1, 32'h1880, 0);
      push(a, K_ACK, '0, 1'b0, 0, 32'h2000);
      push(a + 2, K_WR, CSR_MSTATUS, 1'b1, 32'h1888, 0);
      push(a + 4, K_ACK, '0, 1'b0, 0, 32'h2004);
      push(a + 5, K_GNT, 12'h340, 1'b1, 32'h77, 32'h0);
      wait_ack("combo_trap");
      trap_req = 0;
      wait_ack("combo_mret");
      mret_req = 0;
      step();
      step();
      inst_req = 0;
      step();

      // reset in the middle of a trap sequence (during T_CAUSE)
      trap_req = 1; trap_cause = 32'h3; trap_pc = 32'h3000;
      n = cyc;
      push(n + 1, K_WR, CSR_MEPC, 1'b1, 32'h3000, 0);
      step();
      step();
      rst = 1'b1;
      trap_req = 0;
      step();
      rst = 1'b0;
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_ack", 32'(trap_ack), 0);
      chk("mid_rst_vec", trap_vec, 0);
      chk("mid_rst_wen", 32'(csr_wen), 0);
      chk("mid_rst_addr", 32'(csr_addr), 0);
      chk("mid_rst_gnt", 32'(inst_gnt), 0);
      chk("mcause_kept", csr_mem[CSR_MCAUSE], 32'h7);
      repeat (8) step();
      chk("queue_drained", 32'(exp_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
